sqrt_arbiter: RTL and testbench
===============================

Name: sqrt_arbiter

Overview:
Shares one square_root unit among NUM_REQ requesters using round-robin arbitration. The block latches the granted requester's operand, issues a start pulse to the unit and waits for its ready, then returns the 8-bit root to the granted requester. A watchdog counter aborts an operation that never completes. It sits between requester-side logic and a single square_root instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 16, operand width
ROOT_W, 8, root width (DATA_W/2)
TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT before abort (>=2)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid_i  in  NUM_REQ  per-requester request
req_value_i  in  NUM_REQ*DATA_W  packed operands, requester k at [k*DATA_W +: DATA_W]
req_ready_o  out  NUM_REQ  one-hot accept; request k is taken in the cycle req_valid_i[k] and req_ready_o[k] are both 1
rsp_valid_o  out  NUM_REQ  one-hot, 1-cycle response strobe to the owning requester
rsp_root_o  out  ROOT_W  result, valid while any rsp_valid_o bit is 1
rsp_timeout_o  out  1  qualifies rsp_valid_o: 1 means the operation was aborted and rsp_root_o is 0
busy_o  out  1  high in every state except IDLE
sqrt_value_o  out  DATA_W  operand to the square_root unit
sqrt_start_o  out  1  1-cycle start pulse to the square_root unit
sqrt_ready_i  in  1  ready/done from the square_root unit
sqrt_root_i  in  ROOT_W  root from the square_root unit

Behaviour:
- Reset (async, rst=1): state IDLE, rr_ptr=0, owner=0, operand register 0, all outputs 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant goes to the first requester with req_valid_i set, scanning from rr_ptr upward modulo NUM_REQ.
  - req_ready_o is combinational from req_valid_i and rr_ptr, and is only ever 1 in IDLE.
  - On accept: latch the operand into sqrt_value_o, owner=k, rr_ptr=(k+1) mod NUM_REQ, go to ISSUE.
  - No request: stay in IDLE, rr_ptr unchanged.
- ISSUE: sqrt_start_o=1 for exactly this cycle. Clear seen_low and the watchdog counter, go to WAIT.
- WAIT:
  - The counter increments every cycle.
  - seen_low is set when sqrt_ready_i=0. This rejects a ready left high from the previous operation.
  - Completion: sqrt_ready_i=1 with seen_low already 1 from an earlier cycle. Capture sqrt_root_i and go to RESP with timeout=0.
  - If the counter reaches TIMEOUT_CYCLES-1 with no completion: captured root=0, timeout=1, go to RESP.
  - If completion and timeout occur in the same cycle, completion wins.
- RESP: rsp_valid_o[owner]=1, rsp_root_o and rsp_timeout_o driven from registers for one cycle, then go to IDLE.
- sqrt_value_o stays stable from ISSUE through RESP and changes only on the next accept.
- Minimum turnaround: accept at cycle t, start at t+1, response at t+3+L, where L is the unit's compute time in cycles. The next accept is possible at t+4+L.
- Fairness: a requester that holds req_valid_i waits at most NUM_REQ-1 operations.
- req_valid_i may drop at any time before accept. The block never accepts two requests at once.
- rst asserted mid-operation returns the block to the reset state immediately. Any pending response is lost.

Decomposition:
- Package sqrt_arb_pkg holds:
  - state encoding constants: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3
  - a clog2 helper for the pointer and counter widths
- One sub-module, rr_picker: combinational round-robin first-set search taking req vector and rr_ptr, returning one-hot grant, index and any_valid. It is reused by future shared-resource arbiters.
- Registers use the existing gen_reg style, or local always blocks with async active-high reset.

Test Plan:
- Single requester: req_valid_i[0]=1, value 144, unit model with L=5 -> one start pulse, sqrt_value_o=144, rsp_valid_o=0001 with rsp_root_o=12, timeout 0, busy_o low afterwards.
- All 4 requesting continuously, values 0, 1, 65535, 10000 -> grants in order 0,1,2,3,0. Roots 0, 1, 255, 100 each delivered to the correct rsp_valid_o bit.
- Stale ready: the model holds sqrt_ready_i=1 through ISSUE, drops it for 3 cycles, then raises it -> completion only on the second high. The root is captured at that cycle.
- Timeout: the model never asserts ready, TIMEOUT_CYCLES=64 -> RESP 64 cycles after entering WAIT, rsp_timeout_o=1, rsp_root_o=0, then a normal operation still succeeds.
- Reset mid-WAIT: assert rst for 1 cycle -> all outputs 0 asynchronously, no rsp_valid_o ever issued for the aborted request, rr_ptr=0.
- Requester 2 drops req_valid_i in the same cycle requester 3 raises it (rr_ptr=2) -> grant to 3, no spurious req_ready_o[2].

Source files
------------

// File: rtl/sqrt_arb_pkg.sv
// Shared types and helpers for the square-root arbiter slice.
// The state enum doubles as the documented state encoding.
package sqrt_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Width needed to hold values 0..value-1, never less than one bit.
   function automatic int clog2_min1(input int value);
      int width;
      width = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) begin
            width = i + 1;
         end
      end
      return width;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request at or above rr_ptr, wrapping.
// Kept generic so other shared-resource arbiters can reuse it.
module rr_picker
   import sqrt_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = clog2_min1(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [PTR_W-1:0]   grant_idx,
   output logic               any_valid
);

   logic [PTR_W:0] slot_sum;
   logic [PTR_W-1:0] slot;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_valid = 1'b0;
      slot_sum  = '0;
      slot      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         slot_sum = {1'b0, rr_ptr} + (PTR_W+1)'(i);
         if (slot_sum >= (PTR_W+1)'(NUM_REQ)) begin
            slot_sum = slot_sum - (PTR_W+1)'(NUM_REQ);
         end
         slot = slot_sum[PTR_W-1:0];
         if (!any_valid && req[slot]) begin
            grant[slot] = 1'b1;
            grant_idx   = slot;
            any_valid   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sqrt_arbiter.sv
// Round-robin sharing of one square_root unit among NUM_REQ requesters,
// with a watchdog that aborts an operation whose ready never arrives.
module sqrt_arbiter
   import sqrt_arb_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int DATA_W         = 16,
   parameter int ROOT_W         = 8,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_value_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   output logic [NUM_REQ-1:0]        rsp_valid_o,
   output logic [ROOT_W-1:0]         rsp_root_o,
   output logic                      rsp_timeout_o,
   output logic                      busy_o,
   output logic [DATA_W-1:0]         sqrt_value_o,
   output logic                      sqrt_start_o,
   input  logic                      sqrt_ready_i,
   input  logic [ROOT_W-1:0]         sqrt_root_i
);

   localparam int PTR_W = clog2_min1(NUM_REQ);
   localparam int CNT_W = clog2_min1(TIMEOUT_CYCLES);

   state_t             state;
   state_t             state_next;
   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   owner;
   logic [PTR_W-1:0]   grant_idx;
   logic [NUM_REQ-1:0] grant;
   logic               any_valid;
   logic [DATA_W-1:0]  value_q;
   logic [DATA_W-1:0]  sel_value;
   logic [ROOT_W-1:0]  root_q;
   logic               timeout_q;
   logic               seen_low;
   logic [CNT_W-1:0]   wd_cnt;
   logic               accept;
   logic               done;
   logic               expired;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_picker (
      .req       (req_valid_i),
      .rr_ptr    (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_valid (any_valid)
   );

   always_comb begin
      sel_value = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_idx == PTR_W'(k)) begin
            sel_value = req_value_i[k*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Completion needs a low ready seen in an earlier WAIT cycle, so a ready
   // still high from the previous operation is never mistaken for done.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      done       = 1'b0;
      expired    = 1'b0;
      case (state)
         IDLE: begin
            if (any_valid) begin
               accept     = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            state_next = WAIT;
         end
         WAIT: begin
            done    = sqrt_ready_i && seen_low;
            expired = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
            if (done || expired) begin
               state_next = RESP;
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr    <= '0;
         owner     <= '0;
         value_q   <= '0;
         root_q    <= '0;
         timeout_q <= 1'b0;
         seen_low  <= 1'b0;
         wd_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  value_q <= sel_value;
                  owner   <= grant_idx;
                  rr_ptr  <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
               end
            end
            ISSUE: begin
               seen_low <= 1'b0;
               wd_cnt   <= '0;
            end
            WAIT: begin
               wd_cnt <= wd_cnt + CNT_W'(1);
               if (!sqrt_ready_i) begin
                  seen_low <= 1'b1;
               end
               if (done) begin
                  root_q    <= sqrt_root_i;
                  timeout_q <= 1'b0;
               end else if (expired) begin
                  root_q    <= '0;
                  timeout_q <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign req_ready_o   = (state == IDLE) ? grant : '0;
   assign rsp_valid_o   = (state == RESP) ? (NUM_REQ'(1) << owner) : '0;
   assign rsp_root_o    = (state == RESP) ? root_q : '0;
   assign rsp_timeout_o = (state == RESP) && timeout_q;
   assign busy_o        = (state != IDLE);
   assign sqrt_value_o  = value_q;
   assign sqrt_start_o  = (state == ISSUE);

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Scoreboard bench for sqrt_arbiter: accepts push expected responses,
// a negedge monitor pops and compares whenever a response strobe appears.
module tb_sqrt_arbiter;

   localparam int NUM_REQ        = 4;
   localparam int DATA_W         = 16;
   localparam int ROOT_W         = 8;
   localparam int TIMEOUT_CYCLES = 64;

   localparam int MODE_NORMAL = 0;
   localparam int MODE_NEVER  = 1;
   localparam int MODE_STALE  = 2;

   logic                      clk;
   logic                      rst;
   logic [NUM_REQ-1:0]        req_valid_i;
   logic [NUM_REQ*DATA_W-1:0] req_value_i;
   logic [NUM_REQ-1:0]        req_ready_o;
   logic [NUM_REQ-1:0]        rsp_valid_o;
   logic [ROOT_W-1:0]         rsp_root_o;
   logic                      rsp_timeout_o;
   logic                      busy_o;
   logic [DATA_W-1:0]         sqrt_value_o;
   logic                      sqrt_start_o;
   logic                      sqrt_ready_i;
   logic [ROOT_W-1:0]         sqrt_root_i;

   typedef struct {
      int owner;
      int root;
      int timeout;
      int operand;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;
   int start_count  = 0;
   int rsp_cyc      = 0;
   int acc_cyc      = 0;
   int model_mode   = MODE_NORMAL;
   int model_lat    = 5;

   int               m_lat;
   logic             m_busy;
   logic             m_drop_pend;
   logic [DATA_W-1:0] m_op;

   sqrt_arbiter #(
      .NUM_REQ        (NUM_REQ),
      .DATA_W         (DATA_W),
      .ROOT_W         (ROOT_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid_i   (req_valid_i),
      .req_value_i   (req_value_i),
      .req_ready_o   (req_ready_o),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_root_o    (rsp_root_o),
      .rsp_timeout_o (rsp_timeout_o),
      .busy_o        (busy_o),
      .sqrt_value_o  (sqrt_value_o),
      .sqrt_start_o  (sqrt_start_o),
      .sqrt_ready_i  (sqrt_ready_i),
      .sqrt_root_i   (sqrt_root_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   function automatic logic [ROOT_W-1:0] isqrt(input logic [DATA_W-1:0] v);
      int r;
      r = 0;
      while ((r + 1) * (r + 1) <= int'(v)) r++;
      return ROOT_W'(r);
   endfunction

   // Square-root unit model: ready drops on start and returns after model_lat
   // edges; 8'hEE is driven as root whenever the result is not yet final.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sqrt_ready_i <= 1'b0;
         sqrt_root_i  <= '0;
         m_busy       <= 1'b0;
         m_drop_pend  <= 1'b0;
         m_lat        <= 0;
         m_op         <= '0;
      end else if (sqrt_start_o) begin
         m_op        <= sqrt_value_o;
         sqrt_root_i <= 8'hEE;
         if (model_mode == MODE_NEVER) begin
            sqrt_ready_i <= 1'b0;
            m_busy       <= 1'b0;
         end else if (model_mode == MODE_STALE) begin
            m_busy      <= 1'b1;
            m_lat       <= 4;
            m_drop_pend <= 1'b1;
         end else begin
            sqrt_ready_i <= 1'b0;
            m_busy       <= 1'b1;
            m_lat        <= model_lat;
            m_drop_pend  <= 1'b0;
         end
      end else if (m_busy) begin
         m_drop_pend <= 1'b0;
         if (m_drop_pend) sqrt_ready_i <= 1'b0;
         if (m_lat == 1) begin
            sqrt_ready_i <= 1'b1;
            sqrt_root_i  <= isqrt(m_op);
            m_busy       <= 1'b0;
         end else begin
            m_lat <= m_lat - 1;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (sqrt_start_o) start_count++;
         if (rsp_valid_o != '0) begin
            rsp_cyc = cyc;
            if (exp_q.size() == 0) begin
               checkOutput("unexpected response", 32'(rsp_valid_o), 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               checkOutput("rsp owner", 32'(rsp_valid_o), 32'(1 << mon_e.owner));
               checkOutput("rsp root", 32'(rsp_root_o), 32'(mon_e.root));
               checkOutput("rsp timeout", 32'(rsp_timeout_o), 32'(mon_e.timeout));
               checkOutput("operand held", 32'(sqrt_value_o), 32'(mon_e.operand));
            end
         end
      end
   end

   task automatic applyStimulus(input logic [NUM_REQ-1:0] valid,
                                input logic [DATA_W-1:0] v0, input logic [DATA_W-1:0] v1,
                                input logic [DATA_W-1:0] v2, input logic [DATA_W-1:0] v3);
      req_valid_i = valid;
      req_value_i = {v3, v2, v1, v0};
   endtask

   // Called at a negedge with inputs set; returns at the negedge after the accept.
   task automatic acceptOne(input int k, input int root, input int timeout, input int operand,
                            input bit expect_rsp, input string name);
      int   waited;
      bit   found;
      exp_t e;
      waited = 0;
      found  = 1'b0;
      #1;
      while (!found && waited < 200) begin
         if ((req_ready_o & req_valid_i) != '0) begin
            found = 1'b1;
         end else begin
            @(negedge clk);
            #1;
            waited++;
         end
      end
      checkOutput({name, " accepted"}, 32'(found), 32'd1);
      if (found) begin
         checkOutput({name, " grant"}, 32'(req_ready_o), 32'(1 << k));
         acc_cyc = cyc;
         if (expect_rsp) begin
            e.owner   = k;
            e.root    = root;
            e.timeout = timeout;
            e.operand = operand;
            exp_q.push_back(e);
         end
         @(negedge clk);
      end
   endtask

   task automatic drain(input int budget, input string name);
      int w;
      w = 0;
      while ((busy_o || exp_q.size() != 0) && w < budget) begin
         @(negedge clk);
         w++;
      end
      checkOutput({name, " responses pending"}, 32'(exp_q.size()), 32'd0);
      checkOutput({name, " busy after"}, 32'(busy_o), 32'd0);
   endtask

   task automatic checkAllZero(input string name);
      checkOutput({name, " busy"}, 32'(busy_o), 32'd0);
      checkOutput({name, " req_ready"}, 32'(req_ready_o), 32'd0);
      checkOutput({name, " rsp_valid"}, 32'(rsp_valid_o), 32'd0);
      checkOutput({name, " rsp_root"}, 32'(rsp_root_o), 32'd0);
      checkOutput({name, " rsp_timeout"}, 32'(rsp_timeout_o), 32'd0);
      checkOutput({name, " start"}, 32'(sqrt_start_o), 32'd0);
      checkOutput({name, " value"}, 32'(sqrt_value_o), 32'd0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL global time limit: got no finish, expected finish");
      $fatal(1, "[TB] time limit");
   end

   initial begin
      int base;
      int w;
      rst = 1'b1;
      applyStimulus('0, 16'd0, 16'd0, 16'd0, 16'd0);
      repeat (2) @(negedge clk);
      checkAllZero("reset");
      rst = 1'b0;

      // Four continuous requesters, grants rotate 0,1,2,3,0.
      model_mode = MODE_NORMAL;
      model_lat  = 2;
      @(negedge clk);
      applyStimulus(4'b1111, 16'd0, 16'd1, 16'd65535, 16'd10000);
      acceptOne(0, 0,   0, 0,     1'b1, "rr0");
      acceptOne(1, 1,   0, 1,     1'b1, "rr1");
      acceptOne(2, 255, 0, 65535, 1'b1, "rr2");
      acceptOne(3, 100, 0, 10000, 1'b1, "rr3");
      acceptOne(0, 0,   0, 0,     1'b1, "rr4");
      applyStimulus('0, 16'd0, 16'd0, 16'd0, 16'd0);
      drain(300, "rr");

      // Single request, unit latency 5.
      model_lat = 5;
      base = start_count;
      @(negedge clk);
      applyStimulus(4'b0001, 16'd144, 16'd0, 16'd0, 16'd0);
      acceptOne(0, 12, 0, 144, 1'b1, "single");
      applyStimulus('0, 16'd0, 16'd0, 16'd0, 16'd0);
      drain(100, "single");
      checkOutput("single latency", 32'(rsp_cyc - acc_cyc), 32'd8);
      checkOutput("single start pulses", 32'(start_count - base), 32'd1);

      // Ready left high from the last op must not count as completion.
      model_mode = MODE_STALE;
      @(negedge clk);
      applyStimulus(4'b0010, 16'd0, 16'd49, 16'd0, 16'd0);
      acceptOne(1, 7, 0, 49, 1'b1, "stale");
      applyStimulus('0, 16'd0, 16'd0, 16'd0, 16'd0);
      drain(100, "stale");
      checkOutput("stale latency", 32'(rsp_cyc - acc_cyc), 32'd7);

      // Unit never answers: watchdog abort, then a normal op still works.
      model_mode = MODE_NEVER;
      @(negedge clk);
      applyStimulus(4'b1000, 16'd0, 16'd0, 16'd0, 16'd400);
      acceptOne(3, 0, 1, 400, 1'b1, "timeout");
      applyStimulus('0, 16'd0, 16'd0, 16'd0, 16'd0);
      drain(200, "timeout");
      checkOutput("timeout latency", 32'(rsp_cyc - acc_cyc), 32'd66);
      model_mode = MODE_NORMAL;
      model_lat  = 3;
      @(negedge clk);
      applyStimulus(4'b1000, 16'd0, 16'd0, 16'd0, 16'd400);
      acceptOne(3, 20, 0, 400, 1'b1, "after timeout");
      applyStimulus('0, 16'd0, 16'd0, 16'd0, 16'd0);
      drain(100, "after timeout");
      checkOutput("after timeout latency", 32'(rsp_cyc - acc_cyc), 32'd6);

      // Reset in the middle of WAIT drops the operation without a response.
      model_lat = 20;
      @(negedge clk);
      applyStimulus(4'b0100, 16'd0, 16'd0, 16'd900, 16'd0);
      acceptOne(2, 0, 0, 900, 1'b0, "aborted");
      applyStimulus('0, 16'd0, 16'd0, 16'd0, 16'd0);
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1 checkAllZero("mid reset");
      @(negedge clk);
      #2 rst = 1'b0;

      // Pointer back at 0: requesters 1 and 3 both asking must grant 1.
      model_lat = 5;
      @(negedge clk);
      applyStimulus(4'b1010, 16'd0, 16'd81, 16'd0, 16'd2500);
      #1 checkOutput("rr_ptr after reset", 32'(req_ready_o), 32'b0010);
      applyStimulus(4'b0010, 16'd0, 16'd81, 16'd0, 16'd2500);
      acceptOne(1, 9, 0, 81, 1'b1, "post reset");

      // Requester 2 waits during the op, then drops as requester 3 rises.
      applyStimulus(4'b0100, 16'd0, 16'd0, 16'd1600, 16'd2500);
      repeat (2) @(negedge clk);
      #1 checkOutput("no ready while busy", 32'(req_ready_o), 32'd0);
      w = 0;
      while (busy_o && w < 100) begin
         @(negedge clk);
         w++;
      end
      checkOutput("idle before swap", 32'(busy_o), 32'd0);
      applyStimulus(4'b1000, 16'd0, 16'd0, 16'd1600, 16'd2500);
      acceptOne(3, 50, 0, 2500, 1'b1, "swap");
      applyStimulus('0, 16'd0, 16'd0, 16'd0, 16'd0);
      drain(100, "swap");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
